// File: rtl/ultrasonido_hcsr04_if.sv
// ultrasonido_hcsr04_if: HC-SR04 sensor pins plus the published measurement results.
interface ultrasonido_hcsr04_if #(
    parameter int DIST_W = 9
);
    logic              echo;
    logic              trigger;
    logic [DIST_W-1:0] distancia_cm;
    logic              dato_valido;
    logic              timeout;
    logic              Ultra_sonido;
    modport master (input echo, output trigger, distancia_cm, dato_valido, timeout, Ultra_sonido);
    modport slave (output echo, input trigger, distancia_cm, dato_valido, timeout, Ultra_sonido);
endinterface

// File: rtl/ultrasonido_hcsr04.sv
// ultrasonido_hcsr04: periodic HC-SR04 trigger, echo timing in cm and near-object flag.
module ultrasonido_hcsr04 #(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int UMBRAL_CM      = 20,
    parameter int DIST_W         = 9
) (
    input logic                  clk,
    input logic                  reset,
    ultrasonido_hcsr04_if.master bus
);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(TRIG_CYCLES + 1);
    localparam int SW = $clog2(CYCLES_PER_CM + 1);
    localparam logic [PW-1:0]     PER_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0]     WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]     TRIG_LAST = GW'(TRIG_CYCLES - 1);
    localparam logic [SW-1:0]     SUB_LAST  = SW'(CYCLES_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = '1;
    localparam logic [DIST_W-1:0] UMBRAL    = DIST_W'(UMBRAL_CM);

    typedef enum logic [2:0] {ESPERA, DISPARO, ESP_ECO, MIDE, FIN} estado_t;

    estado_t           estado_q;
    logic              echo_meta_q, echo_sync_q, echo_prev_q;
    logic [PW-1:0]     per_q, per_d;
    logic [GW-1:0]     trig_q;
    logic [TW-1:0]     wait_q;
    logic [SW-1:0]     sub_q, sub_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic              rise, fall, sub_wrap, wait_end;
    logic              trigger_q, dv_q, to_q, us_q;
    logic [DIST_W-1:0] dist_q;

    // cm_d already includes the current cycle, so the falling-edge cycle is counted too
    always_comb begin
        rise     = echo_sync_q & ~echo_prev_q;
        fall     = ~echo_sync_q & echo_prev_q;
        per_d    = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
        sub_wrap = sub_q == SUB_LAST;
        sub_d    = sub_wrap ? '0 : sub_q + 1'b1;
        cm_d     = (sub_wrap && cm_q != CM_MAX) ? cm_q + 1'b1 : cm_q;
        wait_end = wait_q == WAIT_LAST;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= ESPERA;
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_prev_q <= 1'b0;
            per_q       <= '0;
            trig_q      <= '0;
            wait_q      <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            trigger_q   <= 1'b0;
            dist_q      <= '1;
            dv_q        <= 1'b0;
            to_q        <= 1'b0;
            us_q        <= 1'b0;
        end else begin
            {echo_prev_q, echo_sync_q, echo_meta_q} <= {echo_sync_q, echo_meta_q, bus.echo};
            per_q <= per_d;
            dv_q  <= 1'b0;
            case (estado_q)
                ESPERA: if (per_q == '0) begin
                    estado_q  <= DISPARO;
                    trigger_q <= 1'b1;
                    trig_q    <= '0;
                end
                DISPARO: if (trig_q == TRIG_LAST) begin
                    estado_q  <= ESP_ECO;
                    trigger_q <= 1'b0;
                    wait_q    <= '0;
                end else begin
                    trig_q <= trig_q + 1'b1;
                end
                ESP_ECO: if (rise) begin
                    estado_q <= MIDE;
                    wait_q   <= '0;
                    sub_q    <= '0;
                    cm_q     <= '0;
                end else if (wait_end) begin
                    estado_q <= FIN;
                    dist_q   <= '1;
                    to_q     <= 1'b1;
                    us_q     <= 1'b0;
                    dv_q     <= 1'b1;
                end else begin
                    wait_q <= wait_q + 1'b1;
                end
                MIDE: if (fall) begin
                    estado_q <= FIN;
                    dist_q   <= cm_d;
                    to_q     <= 1'b0;
                    us_q     <= cm_d < UMBRAL;
                    dv_q     <= 1'b1;
                end else if (wait_end) begin
                    estado_q <= FIN;
                    dist_q   <= '1;
                    to_q     <= 1'b1;
                    us_q     <= 1'b0;
                    dv_q     <= 1'b1;
                end else begin
                    sub_q  <= sub_d;
                    cm_q   <= cm_d;
                    wait_q <= wait_q + 1'b1;
                end
                FIN:     estado_q <= ESPERA;
                default: estado_q <= ESPERA;
            endcase
        end
    end

    assign bus.trigger      = trigger_q;
    assign bus.distancia_cm = dist_q;
    assign bus.dato_valido  = dv_q;
    assign bus.timeout      = to_q;
    assign bus.Ultra_sonido = us_q;
endmodule
